// File: rtl/mux_pkg.sv
// Shared constants for the mux datapath.
// Holds the default data width and the register reset value.
package mux_pkg;
   localparam int                   MUX_WIDTH     = 32;
   localparam logic [MUX_WIDTH-1:0] MUX_RESET_VAL = '0;
endpackage

// File: rtl/mux2_comb.sv
// Two-way combinational word selector. Zero latency, no clock and no backpressure.
// An unknown select drives X so a bad select is not hidden by a default to either input.
module mux2_comb #(
   parameter int WIDTH = mux_pkg::MUX_WIDTH
) (
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   input  logic             op,
   output logic [WIDTH-1:0] out
);

   always_comb begin
      out = 'x;
      case (op)
         1'b0:    out = input1;
         1'b1:    out = input2;
         default: out = 'x;
      endcase
   end

endmodule

// File: rtl/mux32.sv
// Word mux with a combinational output and a one-clock registered copy.
// Load enable gates the register, synchronous active-low reset has priority, no backpressure.
module mux32
   import mux_pkg::*;
#(
   parameter int               WIDTH     = MUX_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(MUX_RESET_VAL)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   input  logic             op,
   input  logic             en,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             out_q_valid,
   output logic             op_q
);

   logic [WIDTH-1:0] w_out;
   logic [WIDTH-1:0] r_out_q;
   logic             r_op_q;
   logic             r_out_q_valid;

   mux2_comb #(
      .WIDTH (WIDTH)
   ) u_mux2_comb (
      .input1 (input1),
      .input2 (input2),
      .op     (op),
      .out    (w_out)
   );

   // Reset wins over en, so a load presented on a reset edge is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_q       <= RESET_VAL;
         r_op_q        <= 1'b0;
         r_out_q_valid <= 1'b0;
      end else if (en) begin
         r_out_q       <= w_out;
         r_op_q        <= op;
         r_out_q_valid <= 1'b1;
      end
   end

   assign out         = w_out;
   assign out_q       = r_out_q;
   assign op_q        = r_op_q;
   assign out_q_valid = r_out_q_valid;

endmodule

// File: tb/tb_mux32.sv
// Directed bench for mux32: combinational select, registered load/hold, reset priority.
module tb_mux32;

   logic        clk;
   logic        rst_n;
   logic [31:0] input1;
   logic [31:0] input2;
   logic        op;
   logic        en;
   logic [31:0] out;
   logic [31:0] out_q;
   logic        out_q_valid;
   logic        op_q;

   int n_assert;
   int n_fail;

   mux32 dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .input1      (input1),
      .input2      (input2),
      .op          (op),
      .en          (en),
      .out         (out),
      .out_q       (out_q),
      .out_q_valid (out_q_valid),
      .op_q        (op_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] exp_q;
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      en       = 1'b1;
      input1   = 32'hA5A5_A5A5;
      input2   = 32'h5A5A_5A5A;
      op       = 1'b0;

      // combinational path before any clock edge
      #1 check("comb_a5_op0", out, 32'hA5A5_A5A5);
      op = 1'b1;
      #1 check("comb_a5_op1", out, 32'h5A5A_5A5A);
      input1 = 32'hFFFF_FFFF;
      input2 = 32'h0000_0000;
      op     = 1'b0;
      #1 check("comb_ff_op0", out, 32'hFFFF_FFFF);
      op = 1'b1;
      #1 check("comb_ff_op1", out, 32'h0000_0000);
      input1 = 32'hF0F0_1234;
      input2 = 32'h0F0F_ABCD;
      op     = 1'b0;
      #1 check("comb_bitwise_op0", out, 32'hF0F0_1234);

      // two reset edges with en=1
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_out_q", out_q, 32'h0);
      check("rst_op_q", {31'b0, op_q}, 32'h0);
      check("rst_valid", {31'b0, out_q_valid}, 32'h0);
      check("comb_in_reset", out, 32'hF0F0_1234);

      // release reset, load input2
      @(negedge clk);
      rst_n  = 1'b1;
      op     = 1'b1;
      input2 = 32'h5A5A_5A5A;
      @(posedge clk);
      #1;
      check("load_out_q", out_q, 32'h5A5A_5A5A);
      check("load_op_q", {31'b0, op_q}, 32'h1);
      check("load_valid", {31'b0, out_q_valid}, 32'h1);

      // hold with en=0 while inputs change
      @(negedge clk);
      en     = 1'b0;
      op     = 1'b0;
      input1 = 32'h1234_5678;
      #1;
      check("hold_comb_now", out, 32'h1234_5678);
      check("hold_q_now", out_q, 32'h5A5A_5A5A);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("hold_out_q", out_q, 32'h5A5A_5A5A);
         check("hold_op_q", {31'b0, op_q}, 32'h1);
         check("hold_valid", {31'b0, out_q_valid}, 32'h1);
      end
      @(negedge clk);
      en = 1'b1;
      @(posedge clk);
      #1;
      check("reload_out_q", out_q, 32'h1234_5678);
      check("reload_op_q", {31'b0, op_q}, 32'h0);

      // reset on the same edge as new data
      @(negedge clk);
      input1 = 32'hFFFF_FFFF;
      op     = 1'b0;
      en     = 1'b1;
      rst_n  = 1'b0;
      @(posedge clk);
      #1;
      check("rstpri_out_q", out_q, 32'h0);
      check("rstpri_valid", {31'b0, out_q_valid}, 32'h0);
      check("rstpri_op_q", {31'b0, op_q}, 32'h0);
      check("rstpri_comb", out, 32'hFFFF_FFFF);

      // op toggles twice per cycle; register captures the value present at the rising edge
      @(negedge clk);
      rst_n  = 1'b1;
      input1 = 32'hA5A5_A5A5;
      input2 = 32'h5A5A_5A5A;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         op = (i % 3 == 1) ? 1'b1 : ((i % 2 == 0) ? 1'b0 : 1'b1);
         exp_q = op ? 32'h5A5A_5A5A : 32'hA5A5_A5A5;
         #1 check("toggle_comb_lo", out, exp_q);
         @(posedge clk);
         #1;
         check("toggle_out_q", out_q, exp_q);
         check("toggle_op_q", {31'b0, op_q}, {31'b0, (exp_q == 32'h5A5A_5A5A)});
         op = ~op;
         #1 check("toggle_comb_hi", out, op ? 32'h5A5A_5A5A : 32'hA5A5_A5A5);
         check("toggle_q_stable", out_q, exp_q);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mux32.md
MUX32 -- requirements
Module: mux32

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits; all data ports SHALL use WIDTH.
REQ-002 Parameter RESET_VAL, default 0 (WIDTH bits), value loaded into registered outputs on reset.
REQ-003 Port clk, input, 1, single clock; all state SHALL be updated on its rising edge.
REQ-004 Port rst_n, input, 1, reset; one clock, reset synchronous and active-low.
REQ-005 Port input1, input, WIDTH, data selected when op=0.
REQ-006 Port input2, input, WIDTH, data selected when op=1.
REQ-007 Port op, input, 1, select: 0 -> input1, 1 -> input2.
REQ-008 Port en, input, 1, load enable for the registered output path.
REQ-009 Port out, output, WIDTH, combinational mux result.
REQ-010 Port out_q, output, WIDTH, registered mux result.
REQ-011 Port out_q_valid, output, 1, out_q holds data captured since the last reset.
REQ-012 Port op_q, output, 1, select value captured with out_q.

Function
REQ-013 out SHALL equal input1 when op=0 and input2 when op=1, purely combinational, no clock dependency, same-delta update on any input change.
REQ-014 out SHALL NOT depend on clk, rst_n or en; it is valid during reset.
REQ-015 If op is X/Z, out SHALL be X in simulation (no silent default to either input).
REQ-016 On a rising clk edge with rst_n=1 and en=1, out_q SHALL load the current value of out, op_q SHALL load op, and out_q_valid SHALL be set to 1.
REQ-017 On a rising clk edge with rst_n=1 and en=0, out_q, op_q and out_q_valid SHALL hold.
REQ-018 Registered path latency SHALL be exactly one clock: out_q reflects inputs sampled at the preceding edge.
REQ-019 Changes to input1/input2/op between edges SHALL affect out immediately and out_q only at the next enabled edge.
REQ-020 No arithmetic is performed; bit i of every output SHALL derive only from bit i of input1/input2.

Reset
REQ-021 On a rising clk edge with rst_n=0: out_q <= RESET_VAL, op_q <= 0, out_q_valid <= 0, regardless of en.
REQ-022 Reset SHALL take priority over en; asserting rst_n=0 mid-operation discards any pending load.
REQ-023 Before the first clock edge with rst_n=0, registered outputs are undefined; no asynchronous clearing.

Structure
REQ-024 WIDTH default and RESET_VAL default SHALL be defined as constants in the shared package mux_pkg and referenced by mux32.
REQ-025 The combinational selector SHALL be a sub-module mux2_comb (WIDTH-parameterised, ports input1, input2, op, out); mux32 instantiates it and adds the output register stage.
REQ-026 No latches; all sequential logic in a single clocked process.

Verification
REQ-027 input1=A5A5A5A5, input2=5A5A5A5A, op=0 -> out=A5A5A5A5 with no clock; op=1 -> out=5A5A5A5A.
REQ-028 input1=FFFFFFFF, input2=00000000, op=0 -> out=FFFFFFFF; op=1 -> out=00000000.
REQ-029 rst_n=0 for 2 edges, en=1 -> out_q=00000000, op_q=0, out_q_valid=0; release, op=1, input2=5A5A5A5A -> after 1 edge out_q=5A5A5A5A, op_q=1, out_q_valid=1.
REQ-030 out_q=5A5A5A5A, en=0, change op=0 and input1=12345678 -> out=12345678 at once, out_q stays 5A5A5A5A over 3 edges; en=1 -> next edge out_q=12345678.
REQ-031 en=1, rst_n=0 on the same edge as new data FFFFFFFF -> out_q=00000000, out_q_valid=0.
REQ-032 Toggle op every half cycle with input1=A5A5A5A5, input2=5A5A5A5A -> out tracks op combinationally; out_q equals the value selected at each rising edge.
